cmd_frame_parser: RTL and testbench
===================================

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 SHALL have parameter CNT_BYTES, default 2, meaning length-field bytes (1..4), big-endian.
REQ-002 SHALL have parameter ARG_BYTES, default 4, meaning argument bytes for argument-bearing commands (1..8).
REQ-003 SHALL have parameter ARG_CMD, default 8'h05, meaning command code that carries ARG_BYTES argument bytes.
REQ-004 SHALL have parameter CHK_EN, default 0, meaning a trailing 8-bit checksum byte is present when 1.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535, meaning maximum idle cycles between bytes inside a frame (0 disables).
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-008 SHALL have port rok, input, 1, meaning rx byte valid for one cycle.
REQ-009 SHALL have port mosi, input, 8, meaning rx byte.
REQ-010 SHALL have port fifo_done, input, 1, meaning downstream transfer done level (asynchronous source).
REQ-011 SHALL have port cmd, output, 8, meaning last accepted command.
REQ-012 SHALL have port rx_cnt, output, 8*CNT_BYTES, meaning last accepted length.
REQ-013 SHALL have port arg, output, 8*ARG_BYTES, meaning last accepted argument; first byte lands in the MSB.
REQ-014 SHALL have port frm_vld, output, 1, meaning one-cycle pulse on frame acceptance.
REQ-015 SHALL have port frm_err, output, 1, meaning one-cycle pulse on checksum or timeout failure.
REQ-016 SHALL have port busy, output, 1, meaning the parser is mid-frame (state not S_LEN, or byte index not 0).
REQ-017 SHALL have port fe_done, output, 1, meaning one-cycle pulse on a synchronised rising edge of fifo_done.

Function
REQ-018 SHALL use states S_LEN, S_CMD, S_ARG, S_CHK and a byte index counter sized for max(CNT_BYTES, ARG_BYTES).
REQ-019 SHALL accept one byte per rok cycle; bytes are shifted into shadow registers, never directly into the outputs.
REQ-020 SHALL go S_LEN -> S_CMD after CNT_BYTES bytes.
REQ-021 SHALL, in S_CMD on rok: go to S_ARG if mosi==ARG_CMD; else to S_CHK if CHK_EN; else complete the frame.
REQ-022 SHALL go S_ARG -> S_CHK (CHK_EN=1) or complete the frame (CHK_EN=0) after ARG_BYTES bytes.
REQ-023 SHALL compute the checksum as the 8-bit modulo-256 sum of all frame bytes before the checksum byte; in S_CHK, a match completes the frame and a mismatch pulses frm_err.
REQ-024 SHALL, on completion, load cmd, rx_cnt and arg (arg only for ARG_CMD; otherwise arg is held) in the same cycle as the frm_vld pulse, i.e. one cycle after the final rok; then return to S_LEN with index 0.
REQ-025 SHALL leave cmd, rx_cnt and arg unchanged on any error or abort.
REQ-026 SHALL run an idle counter while busy: cleared on rok; at TIMEOUT_CYC it pulses frm_err and returns to S_LEN.
REQ-027 SHALL, when fifo_done is high (raw, same cycle), abort to S_LEN and clear the shadow registers and checksum with no frm_err; fifo_done takes priority over a simultaneous rok.
REQ-028 SHALL ignore rok when ARG/CMD bytes are exhausted is impossible: every rok advances exactly one byte, and the counter wraps to 0 on each state change.
REQ-029 SHALL generate fe_done by two-flop synchronisation of fifo_done followed by rising-edge detect, so fe_done pulses 3 cycles after fifo_done rises.
REQ-030 SHALL never assert frm_vld and frm_err in the same cycle.

Reset
REQ-031 SHALL, on rst, asynchronously set state S_LEN, index 0, all shadow registers, checksum and idle counter to 0, and synchroniser flops to 0.
REQ-032 SHALL, on rst, set cmd=0, rx_cnt=0, arg=0, frm_vld=0, frm_err=0, busy=0 and fe_done=0; a reset mid-frame discards the frame with no pulse.

Structure
REQ-033 SHALL take the state enumeration and the default constants (ARG_CMD, width limits) from shared package uart_fifo_pkg.
REQ-034 SHALL instantiate one sub-module, sync_rise, a two-flop synchroniser with rising-edge pulse used for fe_done.

Verification
REQ-035 SHALL cover: defaults, bytes 00 10 05 11 22 33 44 -> one cycle after the last rok, frm_vld=1, cmd=05, rx_cnt=0010, arg=11223344.
REQ-036 SHALL cover: defaults, bytes 00 08 03 -> frm_vld=1, cmd=03, rx_cnt=0008, arg unchanged from the prior frame.
REQ-037 SHALL cover: CHK_EN=1, bytes 00 02 03 then checksum 05 -> frm_vld; the same frame with checksum 06 -> frm_err=1 and outputs unchanged.
REQ-038 SHALL cover: TIMEOUT_CYC=16, bytes 00 10 then 16 idle cycles -> frm_err pulse, busy=0; next bytes 00 04 01 are parsed as a new frame.
REQ-039 SHALL cover: fifo_done rising coincident with rok mid-arg -> abort with no frm_vld/frm_err, busy=0 next cycle, fe_done pulse 3 cycles later.
REQ-040 SHALL cover: rst asserted mid-S_ARG -> all outputs 0 immediately (asynchronously); a full frame after rst release parses correctly.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the command frame parser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_fifo_pkg;

  // Parser states: length field, command byte, argument bytes, checksum byte.
  typedef enum logic [1:0] {
    S_LEN = 2'd0,
    S_CMD = 2'd1,
    S_ARG = 2'd2,
    S_CHK = 2'd3
  } state_t;

  // Command code that carries an argument field.
  localparam logic [7:0] ARG_CMD_DEF   = 8'h05;

  // Largest supported length-field and argument-field sizes, in bytes.
  localparam int         CNT_BYTES_MAX = 4;
  localparam int         ARG_BYTES_MAX = 8;

  // Width of a byte index able to count to max(cnt_b, arg_b) - 1.
  // Inputs are clamped to the supported maxima.
  function automatic int idx_width(input int cnt_b, input int arg_b);
    int c;
    int a;
    int m;
    c = (cnt_b > CNT_BYTES_MAX) ? CNT_BYTES_MAX : cnt_b;
    a = (arg_b > ARG_BYTES_MAX) ? ARG_BYTES_MAX : arg_b;
    m = (c > a) ? c : a;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// Latency: pulse_o rises 3 clk edges after d_i rises; one cycle wide.
// Backpressure: none; every synchronised rising edge produces a pulse.
// Ports: clk/rst (async active-high), d_i asynchronous level, pulse_o one-cycle pulse.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic sync_dly_q;
  logic pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      meta_q     <= d_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
      pulse_q    <= sync_q & ~sync_dly_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cmd_frame_parser.sv
// Byte-stream command frame parser: [len (CNT_BYTES, BE)] [cmd] [arg if ARG_CMD] [chk if CHK_EN].
// Latency: cmd/rx_cnt/arg and frm_vld update one cycle after the final rok of a frame.
// Backpressure: none; one byte consumed per rok, fifo_done aborts the frame in progress.
// Ports: clk, rst (async active-high); rok/mosi rx byte stream; fifo_done abort level;
//        cmd/rx_cnt/arg last accepted fields; frm_vld/frm_err pulses; busy; fe_done pulse.
module cmd_frame_parser
  import uart_fifo_pkg::*;
#(
  parameter int          CNT_BYTES   = 2,
  parameter int          ARG_BYTES   = 4,
  parameter logic [7:0]  ARG_CMD     = ARG_CMD_DEF,
  parameter bit          CHK_EN      = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rok,
  input  logic [7:0]             mosi,
  input  logic                   fifo_done,
  output logic [7:0]             cmd,
  output logic [8*CNT_BYTES-1:0] rx_cnt,
  output logic [8*ARG_BYTES-1:0] arg,
  output logic                   frm_vld,
  output logic                   frm_err,
  output logic                   busy,
  output logic                   fe_done
);

  localparam int              IDX_W    = idx_width(CNT_BYTES, ARG_BYTES);
  localparam int              LEN_W    = 8 * CNT_BYTES;
  localparam int              ARG_W    = 8 * ARG_BYTES;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(CNT_BYTES - 1);
  localparam logic [IDX_W-1:0] ARG_LAST = IDX_W'(ARG_BYTES - 1);
  localparam logic [31:0]     TO_LIM   = 32'(TIMEOUT_CYC);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_sh_q, len_sh_d;
  logic [7:0]         cmd_sh_q, cmd_sh_d;
  logic [ARG_W-1:0]   arg_sh_q, arg_sh_d;
  logic [7:0]         sum_q, sum_d;
  logic [31:0]        idle_q, idle_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [LEN_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [ARG_W-1:0]   arg_q, arg_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;

  logic               busy_w;
  logic               done;
  logic               fail;
  logic               restart;

  assign busy_w = (state_q != S_LEN) || (idx_q != '0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_sh_d = len_sh_q;
    cmd_sh_d = cmd_sh_q;
    arg_sh_d = arg_sh_q;
    sum_d    = sum_q;
    idle_d   = idle_q;
    cmd_d    = cmd_q;
    rx_cnt_d = rx_cnt_q;
    arg_d    = arg_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    done     = 1'b0;
    fail     = 1'b0;
    restart  = 1'b0;

    if (fifo_done) begin
      // Downstream finished: drop the partial frame silently, even if a byte arrives now.
      restart = 1'b0 | 1'b1;
    end else if (rok) begin
      idle_d = '0;
      case (state_q)
        S_LEN: begin
          len_sh_d = (len_sh_q << 8) | LEN_W'(mosi);
          sum_d    = sum_q + mosi;
          if (idx_q == CNT_LAST) begin
            state_d = S_CMD;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
        S_CMD: begin
          cmd_sh_d = mosi;
          sum_d    = sum_q + mosi;
          idx_d    = '0;
          if (mosi == ARG_CMD) begin
            state_d = S_ARG;
          end else if (CHK_EN) begin
            state_d = S_CHK;
          end else begin
            done    = 1'b1;
          end
        end
        S_ARG: begin
          arg_sh_d = (arg_sh_q << 8) | ARG_W'(mosi);
          sum_d    = sum_q + mosi;
          if (idx_q == ARG_LAST) begin
            idx_d = '0;
            if (CHK_EN) begin
              state_d = S_CHK;
            end else begin
              done    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_CHK: begin
          if (mosi == sum_q) begin
            done = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end
      endcase
    end else if (busy_w) begin
      idle_d = idle_q + 32'd1;
      if ((TO_LIM != 32'd0) && (idle_d == TO_LIM)) begin
        fail = 1'b1;
      end
    end

    // Outputs are loaded from the shadow next-values so the final byte is
    // included in the same cycle it is consumed.
    if (done) begin
      cmd_d    = cmd_sh_d;
      rx_cnt_d = len_sh_d;
      if (cmd_sh_d == ARG_CMD) begin
        arg_d = arg_sh_d;
      end
      vld_d   = 1'b1;
      restart = 1'b1;
    end

    if (fail) begin
      err_d   = 1'b1;
      restart = 1'b1;
    end

    if (restart) begin
      state_d  = S_LEN;
      idx_d    = '0;
      len_sh_d = '0;
      cmd_sh_d = '0;
      arg_sh_d = '0;
      sum_d    = '0;
      idle_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LEN;
      idx_q    <= '0;
      len_sh_q <= '0;
      cmd_sh_q <= '0;
      arg_sh_q <= '0;
      sum_q    <= '0;
      idle_q   <= '0;
      cmd_q    <= '0;
      rx_cnt_q <= '0;
      arg_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_sh_q <= len_sh_d;
      cmd_sh_q <= cmd_sh_d;
      arg_sh_q <= arg_sh_d;
      sum_q    <= sum_d;
      idle_q   <= idle_d;
      cmd_q    <= cmd_d;
      rx_cnt_q <= rx_cnt_d;
      arg_q    <= arg_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  sync_rise u_sync_rise (
    .clk     (clk),
    .rst     (rst),
    .d_i     (fifo_done),
    .pulse_o (fe_done)
  );

  assign cmd     = cmd_q;
  assign rx_cnt  = rx_cnt_q;
  assign arg     = arg_q;
  assign frm_vld = vld_q;
  assign frm_err = err_q;
  assign busy    = busy_w;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser with three instances: defaults, checksum on, short timeout.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_cmd_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rok;
  logic [7:0]  mosi;
  logic        fifo_done;

  logic [7:0]  d_cmd, c_cmd, t_cmd;
  logic [15:0] d_cnt, c_cnt, t_cnt;
  logic [31:0] d_arg, c_arg, t_arg;
  logic        d_vld, c_vld, t_vld;
  logic        d_err, c_err, t_err;
  logic        d_busy, c_busy, t_busy;
  logic        d_fe, c_fe, t_fe;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmd_frame_parser u_def (
    .clk(clk), .rst(rst), .rok(rok[0]), .mosi(mosi), .fifo_done(fifo_done),
    .cmd(d_cmd), .rx_cnt(d_cnt), .arg(d_arg), .frm_vld(d_vld), .frm_err(d_err),
    .busy(d_busy), .fe_done(d_fe)
  );

  cmd_frame_parser #(.CHK_EN(1'b1)) u_chk (
    .clk(clk), .rst(rst), .rok(rok[1]), .mosi(mosi), .fifo_done(fifo_done),
    .cmd(c_cmd), .rx_cnt(c_cnt), .arg(c_arg), .frm_vld(c_vld), .frm_err(c_err),
    .busy(c_busy), .fe_done(c_fe)
  );

  cmd_frame_parser #(.TIMEOUT_CYC(16)) u_to (
    .clk(clk), .rst(rst), .rok(rok[2]), .mosi(mosi), .fifo_done(fifo_done),
    .cmd(t_cmd), .rx_cnt(t_cnt), .arg(t_arg), .frm_vld(t_vld), .frm_err(t_err),
    .busy(t_busy), .fe_done(t_fe)
  );

  // Called at a falling edge; presents one byte for one cycle and returns at the next falling edge.
  task automatic send(input int sel, input logic [7:0] b);
    rok       = '0;
    rok[sel]  = 1'b1;
    mosi      = b;
    @(negedge clk);
    rok       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rok = '0; mosi = 8'h00; fifo_done = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (d_cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd: got %h want 00", d_cmd); end
    n_chk++; if (d_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_rx_cnt: got %h want 0000", d_cnt); end
    n_chk++; if (d_arg !== 32'h0) begin n_fail++; $display("FAIL reset_arg: got %h want 00000000", d_arg); end
    n_chk++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL reset_frm_vld: got %b want 0", d_vld); end
    n_chk++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err: got %b want 0", d_err); end
    n_chk++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", d_busy); end
    n_chk++; if (d_fe !== 1'b0) begin n_fail++; $display("FAIL reset_fe_done: got %b want 0", d_fe); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arg_frame();
    send(0, 8'h00); send(0, 8'h10);
    n_chk++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL argf_busy_mid: got %b want 1", d_busy); end
    send(0, 8'h05); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    n_chk++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL argf_vld_early: got %b want 0", d_vld); end
    send(0, 8'h44);
    n_chk++; if (d_vld !== 1'b1) begin n_fail++; $display("FAIL argf_vld: got %b want 1", d_vld); end
    n_chk++; if (d_cmd !== 8'h05) begin n_fail++; $display("FAIL argf_cmd: got %h want 05", d_cmd); end
    n_chk++; if (d_cnt !== 16'h0010) begin n_fail++; $display("FAIL argf_rx_cnt: got %h want 0010", d_cnt); end
    n_chk++; if (d_arg !== 32'h11223344) begin n_fail++; $display("FAIL argf_arg: got %h want 11223344", d_arg); end
    n_chk++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL argf_busy_end: got %b want 0", d_busy); end
    @(negedge clk);
    n_chk++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL argf_vld_width: got %b want 0", d_vld); end
  endtask

  task automatic test_noarg_frame();
    send(0, 8'h00); send(0, 8'h08); send(0, 8'h03);
    n_chk++; if (d_vld !== 1'b1) begin n_fail++; $display("FAIL noarg_vld: got %b want 1", d_vld); end
    n_chk++; if (d_cmd !== 8'h03) begin n_fail++; $display("FAIL noarg_cmd: got %h want 03", d_cmd); end
    n_chk++; if (d_cnt !== 16'h0008) begin n_fail++; $display("FAIL noarg_rx_cnt: got %h want 0008", d_cnt); end
    n_chk++; if (d_arg !== 32'h11223344) begin n_fail++; $display("FAIL noarg_arg_held: got %h want 11223344", d_arg); end
    @(negedge clk);
  endtask

  task automatic test_checksum();
    // 00+02+03 = 05
    send(1, 8'h00); send(1, 8'h02); send(1, 8'h03);
    n_chk++; if (c_vld !== 1'b0) begin n_fail++; $display("FAIL chk_vld_before_sum: got %b want 0", c_vld); end
    send(1, 8'h05);
    n_chk++; if (c_vld !== 1'b1) begin n_fail++; $display("FAIL chk_good_vld: got %b want 1", c_vld); end
    n_chk++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL chk_good_err: got %b want 0", c_err); end
    n_chk++; if (c_cmd !== 8'h03) begin n_fail++; $display("FAIL chk_good_cmd: got %h want 03", c_cmd); end
    n_chk++; if (c_cnt !== 16'h0002) begin n_fail++; $display("FAIL chk_good_rx_cnt: got %h want 0002", c_cnt); end
    send(1, 8'h00); send(1, 8'h02); send(1, 8'h03); send(1, 8'h06);
    n_chk++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL chk_bad_err: got %b want 1", c_err); end
    n_chk++; if (c_vld !== 1'b0) begin n_fail++; $display("FAIL chk_bad_vld: got %b want 0", c_vld); end
    // 00+09+07 = 10, send 11
    send(1, 8'h00); send(1, 8'h09); send(1, 8'h07); send(1, 8'h11);
    n_chk++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL chk_bad2_err: got %b want 1", c_err); end
    n_chk++; if (c_cmd !== 8'h03) begin n_fail++; $display("FAIL chk_bad2_cmd_held: got %h want 03", c_cmd); end
    n_chk++; if (c_cnt !== 16'h0002) begin n_fail++; $display("FAIL chk_bad2_rx_cnt_held: got %h want 0002", c_cnt); end
    // 00+01+05+01+02+03+04 = 10
    send(1, 8'h00); send(1, 8'h01); send(1, 8'h05);
    send(1, 8'h01); send(1, 8'h02); send(1, 8'h03); send(1, 8'h04); send(1, 8'h10);
    n_chk++; if (c_vld !== 1'b1) begin n_fail++; $display("FAIL chk_arg_vld: got %b want 1", c_vld); end
    n_chk++; if (c_arg !== 32'h01020304) begin n_fail++; $display("FAIL chk_arg_arg: got %h want 01020304", c_arg); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int k;
    int hit;
    int vld_seen;
    hit = 0;
    vld_seen = 0;
    send(2, 8'h00); send(2, 8'h10);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (t_vld === 1'b1) vld_seen = 1;
      if (t_err === 1'b1) begin
        hit = k;
        break;
      end
    end
    n_chk++; if (hit != 16) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 16 (0 means no pulse in 40 cycles)", hit); end
    n_chk++; if (t_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", t_busy); end
    n_chk++; if (vld_seen != 0) begin n_fail++; $display("FAIL timeout_no_vld: got %0d want 0", vld_seen); end
    @(negedge clk);
    n_chk++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_width: got %b want 0", t_err); end
    send(2, 8'h00); send(2, 8'h04); send(2, 8'h01);
    n_chk++; if (t_vld !== 1'b1) begin n_fail++; $display("FAIL timeout_next_vld: got %b want 1", t_vld); end
    n_chk++; if (t_cmd !== 8'h01) begin n_fail++; $display("FAIL timeout_next_cmd: got %h want 01", t_cmd); end
    n_chk++; if (t_cnt !== 16'h0004) begin n_fail++; $display("FAIL timeout_next_rx_cnt: got %h want 0004", t_cnt); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    send(0, 8'h00); send(0, 8'h10); send(0, 8'h05); send(0, 8'h11); send(0, 8'h22);
    rok[0] = 1'b1; mosi = 8'h33; fifo_done = 1'b1;
    @(negedge clk);
    rok = '0;
    n_chk++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", d_busy); end
    n_chk++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL abort_vld: got %b want 0", d_vld); end
    n_chk++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b want 0", d_err); end
    n_chk++; if (d_fe !== 1'b0) begin n_fail++; $display("FAIL abort_fe_c1: got %b want 0", d_fe); end
    @(negedge clk);
    n_chk++; if (d_fe !== 1'b0) begin n_fail++; $display("FAIL abort_fe_c2: got %b want 0", d_fe); end
    @(negedge clk);
    n_chk++; if (d_fe !== 1'b1) begin n_fail++; $display("FAIL abort_fe_c3: got %b want 1", d_fe); end
    @(negedge clk);
    n_chk++; if (d_fe !== 1'b0) begin n_fail++; $display("FAIL abort_fe_c4: got %b want 0", d_fe); end
    fifo_done = 1'b0;
    repeat (3) @(negedge clk);
    send(0, 8'h00); send(0, 8'h06); send(0, 8'h09);
    n_chk++; if (d_vld !== 1'b1) begin n_fail++; $display("FAIL abort_next_vld: got %b want 1", d_vld); end
    n_chk++; if (d_cmd !== 8'h09) begin n_fail++; $display("FAIL abort_next_cmd: got %h want 09", d_cmd); end
    n_chk++; if (d_cnt !== 16'h0006) begin n_fail++; $display("FAIL abort_next_rx_cnt: got %h want 0006", d_cnt); end
    n_chk++; if (d_arg !== 32'h11223344) begin n_fail++; $display("FAIL abort_next_arg_held: got %h want 11223344", d_arg); end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    send(0, 8'h00); send(0, 8'h10); send(0, 8'h05); send(0, 8'h11);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (d_cmd !== 8'h00) begin n_fail++; $display("FAIL rstmid_cmd: got %h want 00", d_cmd); end
    n_chk++; if (d_cnt !== 16'h0000) begin n_fail++; $display("FAIL rstmid_rx_cnt: got %h want 0000", d_cnt); end
    n_chk++; if (d_arg !== 32'h0) begin n_fail++; $display("FAIL rstmid_arg: got %h want 00000000", d_arg); end
    n_chk++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", d_busy); end
    n_chk++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld: got %b want 0", d_vld); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'h00); send(0, 8'h10); send(0, 8'h05);
    send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC); send(0, 8'hDD);
    n_chk++; if (d_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_vld: got %b want 1", d_vld); end
    n_chk++; if (d_cmd !== 8'h05) begin n_fail++; $display("FAIL rstmid_next_cmd: got %h want 05", d_cmd); end
    n_chk++; if (d_cnt !== 16'h0010) begin n_fail++; $display("FAIL rstmid_next_rx_cnt: got %h want 0010", d_cnt); end
    n_chk++; if (d_arg !== 32'hAABBCCDD) begin n_fail++; $display("FAIL rstmid_next_arg: got %h want AABBCCDD", d_arg); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arg_frame();
    test_noarg_frame();
    test_checksum();
    test_timeout();
    test_abort();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
